// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// Adds two WIDTH-bit operands plus a carry-in, LSB first, by running one
// 1-bit full_adder cell for WIDTH clock cycles. The requester raises START in
// IDLE and collects SUM/C_OUT when DONE pulses.
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RST    in   1      synchronous active-high reset
//   START  in   1      begin an add (only honoured in IDLE)
//   A, B   in   WIDTH  operands, captured on the accepted START edge
//   C_IN   in   1      carry-in, captured with A/B
//   BUSY   out  1      high while an add is in flight (SHIFT, FINISH)
//   DONE   out  1      one-cycle pulse, SUM/C_OUT valid from this cycle
//   SUM    out  WIDTH  registered sum, held until the next completion
//   C_OUT  out  1      registered carry-out, held with SUM
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for START; SUM/C_OUT hold the previous result
// SHIFT  | one operand bit per edge through the full adder, WIDTH edges
// FINISH | DONE pulse for one cycle, then back to IDLE

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (cy),
        .s  (fa_sum),
        .co (fa_carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (START) state_nxt = S_SHIFT;
            S_SHIFT:  if (last_bit) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            C_OUT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_sr <= A;
                        b_sr <= B;
                        cy   <= C_IN;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    s_sr <= {fa_sum, s_sr[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= fa_carry;
                    cnt  <= cnt + CW'(1);
                    // the final sum bit is still in flight, so the result is
                    // assembled from the adder output rather than from s_sr
                    if (last_bit) begin
                        SUM   <= {fa_sum, s_sr[WIDTH-1:1]};
                        C_OUT <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state == S_SHIFT) || (state == S_FINISH);
    assign DONE = (state == S_FINISH);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       C_IN;
    logic       BUSY;
    logic       DONE;
    logic [7:0] SUM;
    logic       C_OUT;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       c2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt  = 0;
    int done2_cnt = 0;
    logic [8:0] last_res;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .C_IN  (C_IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .C_OUT (C_OUT)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .CLK   (CLK),
        .RST   (RST),
        .START (start2),
        .A     (a2),
        .B     (b2),
        .C_IN  (c2),
        .BUSY  (busy2),
        .DONE  (done2),
        .SUM   (sum2),
        .C_OUT (cout2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DONE is high for whole cycles, so each pulse contains exactly one negedge
    always @(negedge CLK) begin
        if (DONE === 1'b1) done_cnt++;
        if (done2 === 1'b1) done2_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called #1 after the accepting edge. Scrambles the inputs while the add is
    // in flight and returns #1 after the edge that raises DONE.
    task automatic finish_add(input string tag, input logic [8:0] exp, input logic [8:0] prev);
        int   k;
        int   busy_n;
        logic held;
        k      = 0;
        busy_n = (BUSY === 1'b1) ? 1 : 0;
        held   = 1'b1;
        while (DONE !== 1'b1 && k < 20) begin
            A    = 8'($urandom);
            B    = 8'($urandom);
            C_IN = 1'($urandom);
            tick();
            k++;
            if (BUSY === 1'b1) busy_n++;
            if (DONE !== 1'b1 && {C_OUT, SUM} !== prev) held = 1'b0;
        end
        check({tag, "_done_seen"}, 32'(DONE), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        check({tag, "_held_until_done"}, 32'(held), 32'd1);
        check({tag, "_result"}, 32'({C_OUT, SUM}), 32'(exp));
        last_res = exp;
    endtask

    task automatic do_add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] exp;
        exp   = 9'(a) + 9'(b) + 9'(ci);
        A     = a;
        B     = b;
        C_IN  = ci;
        START = 1'b1;
        tick();
        START = 1'b0;
        check({tag, "_busy_after_start"}, 32'(BUSY), 32'd1);
        finish_add(tag, exp, last_res);
        tick();
        check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_idle_done"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          n;
        int          d0;
        logic [2:0]  exp2;

        RST    = 1'b1;
        START  = 1'b0;
        A      = '0;
        B      = '0;
        C_IN   = 1'b0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        c2     = 1'b0;
        last_res = '0;

        tick();
        tick();
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_sum", 32'({C_OUT, SUM}), 32'd0);
        check("reset_busy2", 32'(busy2), 32'd0);
        RST = 1'b0;
        tick();

        do_add8("zero", 8'h00, 8'h00, 1'b0);
        do_add8("ff_01", 8'hFF, 8'h01, 1'b0);
        do_add8("a5_5a_c", 8'hA5, 8'h5A, 1'b1);
        do_add8("7f_01", 8'h7F, 8'h01, 1'b0);

        // START held through an add: FINISH ignores it, next IDLE restarts
        A     = 8'h12;
        B     = 8'h34;
        C_IN  = 1'b0;
        START = 1'b1;
        tick();
        finish_add("hold", 9'h046, last_res);
        A    = 8'h20;
        B    = 8'h03;
        C_IN = 1'b0;
        tick();
        check("hold_finish_ignored", 32'(BUSY), 32'd0);
        check("hold_sum_kept", 32'({C_OUT, SUM}), 32'h046);
        tick();
        check("hold_restart_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
        finish_add("restart", 9'h023, 9'h046);
        tick();

        // reset during the fourth SHIFT cycle aborts the add
        A     = 8'hF0;
        B     = 8'h0F;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        d0  = done_cnt;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_result", 32'({C_OUT, SUM}), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        last_res = '0;
        do_add8("after_abort", 8'h01, 8'h01, 1'b0);

        // randomized adds against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            do_add8("rand", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // WIDTH=2: every {A,B,C_IN} back to back with START held
        cyc = 0;
        d0  = done2_cnt;
        start2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            {a2, b2, c2} = 5'(i);
            exp2 = 3'(a2) + 3'(b2) + 3'(c2);
            tick();
            cyc++;
            n = 0;
            while (done2 !== 1'b1 && n < 8) begin
                tick();
                cyc++;
                n++;
            end
            check("w2_done_seen", 32'(done2), 32'd1);
            check("w2_result", 32'({cout2, sum2}), 32'(exp2));
            tick();
            cyc++;
        end
        start2 = 1'b0;
        tick();
        check("w2_cycles", 32'(cyc), 32'd128);
        check("w2_done_count", 32'(done2_cnt - d0), 32'd32);
        check("w2_idle", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
